cam_capture: RTL and testbench

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_capture.sv | 193 +++++++++++++++++++
 tb/tb_cam_capture.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture.sv
// cam_capture
// Captures an RGB565 byte stream from a parallel camera, decimates it by
// 2^DEC_SH in both directions, converts each kept pixel to RGB332 and writes
// it to a row-major frame buffer of OUT_W x OUT_H pixels.
//
// Ports
//   clk50       system clock, rising edge
//   rst_n       asynchronous active-low reset
//   cam_pclk    camera pixel clock, asynchronous, oversampled as data
//   cam_href    camera line valid
//   cam_vsync   camera frame sync (high between frames)
//   cam_data    camera byte, RGB565 high byte first
//   capture_en  level request for continuous capture
//   wr_addr     frame buffer address, y*OUT_W+x
//   wr_data     RGB332 pixel {R[2:0],G[2:0],B[1:0]}
//   wr_en       one-cycle write strobe
//   frame_done  one-cycle pulse when a frame ends
//   busy        high while waiting for or capturing a frame
module cam_capture #(
  parameter int OUT_W  = 160,
  parameter int OUT_H  = 120,
  parameter int DEC_SH = 2
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        cam_pclk,
  input  logic        cam_href,
  input  logic        cam_vsync,
  input  logic [7:0]  cam_data,
  input  logic        capture_en,
  output logic [14:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic        frame_done,
  output logic        busy
);

  localparam logic [14:0] LAST_ADDR = 15'(OUT_W * OUT_H - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE} state_t;

  // Synchronizer chains; data takes the same two-register path so it stays
  // aligned with the synchronized pclk edge.
  logic       pclk_s1_q, pclk_s2_q, pclk_prev_q;
  logic       href_s1_q, href_s2_q, href_prev_q;
  logic       vsync_s1_q, vsync_s2_q, vsync_prev_q;
  logic [7:0] data_s1_q, data_s2_q;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] sx_q, sx_d;
  logic [15:0] sy_q, sy_d;
  logic [14:0] addr_q, addr_d;
  logic        full_q, full_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic        frame_done_q, frame_done_d;
  logic        busy_q, busy_d;

  logic pclk_rise, byte_valid, href_fall, vsync_fall, vsync_rise;
  logic keep_pixel, full_now;

  assign pclk_rise  = pclk_s2_q & ~pclk_prev_q;
  assign byte_valid = pclk_rise & href_s2_q;
  assign href_fall  = href_prev_q & ~href_s2_q;
  assign vsync_fall = vsync_prev_q & ~vsync_s2_q;
  assign vsync_rise = vsync_s2_q & ~vsync_prev_q;

  assign keep_pixel = (sx_q[DEC_SH-1:0] == '0) && (sy_q[DEC_SH-1:0] == '0);
  // Also covers the cycle in which the last address is being written, so a
  // following pixel can never slip past the end of the buffer.
  assign full_now   = full_q | (wr_en_q && (addr_q == LAST_ADDR));

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    addr_d       = addr_q;
    full_d       = full_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;

    // Address moves on the cycle after a write; it sticks at the last
    // location once that has been written.
    if (wr_en_q) begin
      if (addr_q == LAST_ADDR) full_d = 1'b1;
      else                     addr_d = addr_q + 15'd1;
    end

    case (state_q)
      IDLE: begin
        if (capture_en && vsync_s2_q) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (vsync_fall) begin
          state_d = CAPTURE;
          phase_d = 1'b0;
          sx_d    = '0;
          sy_d    = '0;
          addr_d  = '0;
          full_d  = 1'b0;
        end
      end
      CAPTURE: begin
        if (vsync_rise) begin
          state_d      = capture_en ? WAIT_SOF : IDLE;
          frame_done_d = 1'b1;
        end else if (href_fall) begin
          // A pending high byte from an odd-length line is simply dropped.
          sx_d    = '0;
          phase_d = 1'b0;
          sy_d    = sy_q + 16'd1;
        end else if (byte_valid) begin
          if (!phase_q) begin
            hi_d    = data_s2_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            sx_d    = sx_q + 16'd1;
            if (keep_pixel && !full_now) begin
              wr_en_d   = 1'b1;
              wr_data_d = {hi_q[7:5], hi_q[2:0], data_s2_q[4:3]};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      pclk_s1_q    <= 1'b0;
      pclk_s2_q    <= 1'b0;
      pclk_prev_q  <= 1'b0;
      href_s1_q    <= 1'b0;
      href_s2_q    <= 1'b0;
      href_prev_q  <= 1'b0;
      vsync_s1_q   <= 1'b0;
      vsync_s2_q   <= 1'b0;
      vsync_prev_q <= 1'b0;
      data_s1_q    <= '0;
      data_s2_q    <= '0;
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      addr_q       <= '0;
      full_q       <= 1'b0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      pclk_s1_q    <= cam_pclk;
      pclk_s2_q    <= pclk_s1_q;
      pclk_prev_q  <= pclk_s2_q;
      href_s1_q    <= cam_href;
      href_s2_q    <= href_s1_q;
      href_prev_q  <= href_s2_q;
      vsync_s1_q   <= cam_vsync;
      vsync_s2_q   <= vsync_s1_q;
      vsync_prev_q <= vsync_s2_q;
      data_s1_q    <= cam_data;
      data_s2_q    <= data_s1_q;
      state_q      <= state_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      addr_q       <= addr_d;
      full_q       <= full_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign wr_addr    = addr_q;
  assign wr_data    = wr_data_q;
  assign wr_en      = wr_en_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture
// Directed bench for cam_capture on a reduced 4x3 output frame with 4:1
// decimation (16x12 source). Gradient pixels encode source coordinates:
//   hi = {y[4:2], 2'b11, x[4:2]}, lo = {3'b111, x[3:2], 3'b111}
// so the RGB332 result for a kept source pixel is {y[4:2], x[4:2], x[3:2]}.
module tb_cam_capture;

  logic        clk50 = 1'b0;
  logic        rst_n;
  logic        cam_pclk, cam_href, cam_vsync;
  logic [7:0]  cam_data;
  logic        capture_en;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en, frame_done, busy;

  cam_capture #(.OUT_W(4), .OUT_H(3), .DEC_SH(2)) dut (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .cam_pclk   (cam_pclk),
    .cam_href   (cam_href),
    .cam_vsync  (cam_vsync),
    .cam_data   (cam_data),
    .capture_en (capture_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk50 = ~clk50;

  int n_vec = 0;
  int n_err = 0;

  // Write monitor: frame buffer image, write count, ordering, frame_done count.
  logic [7:0] mem [0:15];
  int         wr_cnt, fd_cnt;
  logic [14:0] exp_addr;
  logic       seq_ok;

  always @(negedge clk50) begin
    if (rst_n) begin
      if (wr_en) begin
        if (wr_addr < 15'd16) mem[wr_addr[3:0]] = wr_data;
        if (wr_addr !== exp_addr) seq_ok = 1'b0;
        exp_addr = exp_addr + 15'd1;
        wr_cnt++;
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    wr_cnt   = 0;
    fd_cnt   = 0;
    exp_addr = '0;
    seq_ok   = 1'b1;
  endtask

  // One camera byte: pclk low for 3 cycles, high for 3 cycles.
  task automatic cam_byte(input logic [7:0] b);
    cam_data = b;
    cam_pclk = 1'b0;
    repeat (3) @(negedge clk50);
    cam_pclk = 1'b1;
    repeat (3) @(negedge clk50);
  endtask

  task automatic blank_bytes(input int n);
    for (int i = 0; i < n; i++) cam_byte(8'h00);
  endtask

  // mode 0: constant hi=F8 lo=1F; mode 1: coordinate gradient.
  task automatic cam_line(input int nbytes, input int y, input int mode);
    logic [4:0] xs, ys;
    logic [7:0] b;
    ys = 5'(y);
    cam_href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      xs = 5'(i / 2);
      if (mode == 0) b = (i % 2 == 0) ? 8'hF8 : 8'h1F;
      else if (i % 2 == 0) b = {ys[4:2], 2'b11, xs[4:2]};
      else b = {3'b111, xs[3:2], 3'b111};
      cam_byte(b);
    end
    cam_href = 1'b0;
    blank_bytes(2);
  endtask

  task automatic frame_start();
    cam_vsync = 1'b1;
    repeat (10) @(negedge clk50);
    cam_vsync = 1'b0;
    blank_bytes(2);
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    repeat (10) @(negedge clk50);
  endtask

  task automatic full_frame(input int nlines, input int mode);
    frame_start();
    for (int y = 0; y < nlines; y++) cam_line(32, y, mode);
    frame_end();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hAA;
    clear_stats();
    rst_n      = 1'b0;
    cam_pclk   = 1'b0;
    cam_href   = 1'b0;
    cam_vsync  = 1'b0;
    cam_data   = 8'h00;
    capture_en = 1'b0;
    repeat (4) @(negedge clk50);
    check("reset_outputs", {16'd0, busy, wr_en, frame_done, wr_data, wr_addr[12:0]}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk50);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Constant-colour frame.
    capture_en = 1'b1;
    clear_stats();
    full_frame(12, 0);
    check("const_writes", wr_cnt, 12);
    check("const_order", {31'd0, seq_ok}, 32'd1);
    check("const_done", fd_cnt, 1);
    check("const_px0", {24'd0, mem[0]}, 32'hE3);
    check("const_px11", {24'd0, mem[11]}, 32'hE3);
    check("const_addr_hold", {17'd0, wr_addr}, 32'd11);
    check("const_busy_wait", {31'd0, busy}, 32'd1);

    // Gradient frame.
    clear_stats();
    full_frame(12, 1);
    check("grad_writes", wr_cnt, 12);
    check("grad_px0", {24'd0, mem[0]}, 32'h00);
    check("grad_px5", {24'd0, mem[5]}, 32'h25);
    check("grad_px11", {24'd0, mem[11]}, 32'h4F);
    check("grad_done", fd_cnt, 1);

    // Too many lines: writes stop at the last address.
    clear_stats();
    full_frame(20, 1);
    check("tall_writes", wr_cnt, 12);
    check("tall_order", {31'd0, seq_ok}, 32'd1);
    check("tall_addr_hold", {17'd0, wr_addr}, 32'd11);
    check("tall_done", fd_cnt, 1);

    // First line has an odd byte count; following lines must stay aligned.
    clear_stats();
    frame_start();
    cam_line(31, 0, 1);
    for (int y = 1; y < 12; y++) cam_line(32, y, 1);
    frame_end();
    check("odd_writes", wr_cnt, 12);
    check("odd_px3", {24'd0, mem[3]}, 32'h0F);
    check("odd_px4", {24'd0, mem[4]}, 32'h20);
    check("odd_px5", {24'd0, mem[5]}, 32'h25);

    // Short frame: ends early, still signals done, rest of buffer untouched.
    clear_stats();
    full_frame(5, 0);
    check("short_writes", wr_cnt, 8);
    check("short_done", fd_cnt, 1);
    check("short_px7", {24'd0, mem[7]}, 32'hE3);
    check("short_px8_kept", {24'd0, mem[8]}, 32'h40);

    // capture_en dropped mid-frame: frame completes, then idle.
    clear_stats();
    frame_start();
    for (int y = 0; y < 12; y++) begin
      if (y == 6) capture_en = 1'b0;
      cam_line(32, y, 0);
    end
    frame_end();
    check("drop_writes", wr_cnt, 12);
    check("drop_done", fd_cnt, 1);
    check("drop_idle", {31'd0, busy}, 32'd0);
    clear_stats();
    full_frame(12, 0);
    check("idle_frame_writes", wr_cnt, 0);
    check("idle_frame_done", fd_cnt, 0);

    // Reset pulsed mid-frame.
    capture_en = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'hAA;
    clear_stats();
    frame_start();
    for (int y = 0; y < 8; y++) cam_line(32, y, 1);
    check("pre_reset_addr", {17'd0, wr_addr}, 32'd8);
    check("pre_reset_data", {24'd0, wr_data}, 32'h2F);
    rst_n = 1'b0;
    #1;
    check("reset_midframe", {16'd0, busy, wr_en, frame_done, wr_data, wr_addr[12:0]}, 32'd0);
    repeat (3) @(negedge clk50);
    rst_n = 1'b1;
    for (int y = 8; y < 12; y++) cam_line(32, y, 1);
    frame_end();
    check("aborted_done", fd_cnt, 0);
    check("aborted_writes", wr_cnt, 8);
    clear_stats();
    full_frame(12, 1);
    check("resume_writes", wr_cnt, 12);
    check("resume_order", {31'd0, seq_ok}, 32'd1);
    check("resume_done", fd_cnt, 1);
    check("resume_px5", {24'd0, mem[5]}, 32'h25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
